burst_accumulator: RTL

Sequential accumulation stage placed directly downstream of the 16-bit adder datapath. It accepts a burst of unsigned operands over a valid/ready handshake and keeps a running sum, adding each new operand to the registered total. On the final beat it presents the sum, operand count and an overflow flag to the consumer, holding them until the consumer accepts.

---
 rtl/burst_accumulator.sv | 100 ++++++++++
 1 files changed

// File: rtl/burst_accumulator.sv
// Burst accumulator: sums a valid/ready burst of unsigned operands and presents sum/count/overflow.
// Optional build macro BURST_ACC_SAT_EN selects a saturating sum instead of a wrapping one.
module burst_accumulator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_SUM,
  output logic [CNT_W-1:0] OUT_CNT,
  output logic             OUT_OVF,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int unsigned EXT_W = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic [EXT_W-1:0]   sum_ext;

  // State and datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      ovf       <= ovf_nxt;
      IN_READY  <= (state_nxt != DONE);
      OUT_VALID <= (state_nxt == DONE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    sum_ext   = EXT_W'({1'b0, acc}) + EXT_W'({1'b0, IN_DATA});
    case (state)
      IDLE: begin
        if (IN_VALID) begin
          acc_nxt   = IN_DATA;
          cnt_nxt   = CNT_W'(1);
          ovf_nxt   = 1'b0;
          state_nxt = IN_LAST ? DONE : ACC;
        end
      end
      ACC: begin
        if (IN_VALID) begin
`ifdef BURST_ACC_SAT_EN
          // Once saturated, any further add either carries or adds zero, so acc stays all-ones.
          acc_nxt = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
          acc_nxt = sum_ext[WIDTH-1:0];
`endif
          ovf_nxt   = ovf | sum_ext[WIDTH];
          cnt_nxt   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
          state_nxt = IN_LAST ? DONE : ACC;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign OUT_SUM = acc;
  assign OUT_CNT = cnt;
  assign OUT_OVF = ovf;

endmodule
